// File: rtl/cmos_pixel_capture_if.sv
// Camera user interface driven by the CMOS capture stage: gated frame sync,
// pixel strobe, pixel-rate clock phase, pixel data in two formats and position counters.
interface cmos_pixel_capture_if #(
    parameter int CNT_W = 12
);
    logic             vsync;
    logic             de;
    logic             half_cmos_clk;
    logic [15:0]      data_bgr565;
    logic [23:0]      data_bgr888;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] line_y;
    logic             line_err;

    modport master (
        output vsync, de, half_cmos_clk, data_bgr565, data_bgr888,
               pixel_x, line_y, line_err
    );

    modport slave (
        input  vsync, de, half_cmos_clk, data_bgr565, data_bgr888,
               pixel_x, line_y, line_err
    );
endinterface

// File: rtl/cmos_pixel_capture.sv
// CMOS sensor capture: registers the byte stream, drops the first frames after
// configuration, assembles byte pairs into BGR565/BGR888 pixels with position counters.
module cmos_pixel_capture #(
    parameter int SKIP_FRAMES = 10,
    parameter int CNT_W       = 12
) (
    input  logic                 cmos_pclk,
    input  logic                 rst,
    input  logic                 cam_init_done,
    input  logic                 cmos_vsync,
    input  logic                 cmos_href,
    input  logic [7:0]           cmos_db,
    cmos_pixel_capture_if.master cam
);
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} gate_e;

    gate_e             state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              vs_q, vs_d, hr_q, hr_d, vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
    logic [7:0]        db_q, db_d, hi_q, hi_d;
    logic              phase_q, phase_d;
    logic [CNT_W-1:0]  px_cnt_q, px_cnt_d, pixel_x_q, pixel_x_d, line_y_q, line_y_d;
    logic              de_q, de_d, vsync_q, vsync_d, half_q, half_d, line_err_q, line_err_d;
    logic [15:0]       bgr565_q, bgr565_d;
    logic [23:0]       bgr888_q, bgr888_d;
    logic              vs_rise, hr_rise, hr_fall, pix_done, active;
    logic [15:0]       pix;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        vs_d       = cmos_vsync;
        hr_d       = cmos_href;
        db_d       = cmos_db;
        vs_prev_d  = vs_q;
        hr_prev_d  = hr_q;
        vs_rise    = vs_q & ~vs_prev_q;
        hr_rise    = hr_q & ~hr_prev_q;
        hr_fall    = ~hr_q & hr_prev_q;
        phase_d    = hr_q ? ~phase_q : 1'b0;
        hi_d       = (hr_q && !phase_q) ? db_q : hi_q;
        pix_done   = hr_q & phase_q;
        pix        = {hi_q, db_q};

        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (!cam_init_done) begin
            state_d    = IDLE;
            skip_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE:    state_d = SKIP;
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) state_d = ACTIVE;
                        else                                     skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
                ACTIVE:  state_d = ACTIVE;
                default: state_d = IDLE;
            endcase
        end
        // Gating on the next state makes an init drop suppress the in-flight pixel
        // and lets vsync open on the very frame edge that activates the gate.
        active     = (state_d == ACTIVE);

        de_d       = pix_done & active;
        bgr565_d   = bgr565_q;
        bgr888_d   = bgr888_q;
        pixel_x_d  = pixel_x_q;
        px_cnt_d   = px_cnt_q;
        line_y_d   = line_y_q;
        if (de_d) begin
            bgr565_d  = pix;
            bgr888_d  = {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
            pixel_x_d = px_cnt_q;
            px_cnt_d  = sat_inc(px_cnt_q);
        end
        if (active) begin
            if (hr_rise) px_cnt_d = '0;
            if (vs_rise)      line_y_d = '0;
            else if (hr_fall) line_y_d = sat_inc(line_y_q);
        end

        vsync_d    = vs_q & active;
        half_d     = hr_rise ? 1'b0 : ~half_q;
        line_err_d = hr_fall & phase_q;
    end

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
            vs_q       <= 1'b0;
            hr_q       <= 1'b0;
            db_q       <= '0;
            vs_prev_q  <= 1'b0;
            hr_prev_q  <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            px_cnt_q   <= '0;
            pixel_x_q  <= '0;
            line_y_q   <= '0;
            de_q       <= 1'b0;
            vsync_q    <= 1'b0;
            half_q     <= 1'b0;
            line_err_q <= 1'b0;
            bgr565_q   <= '0;
            bgr888_q   <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            vs_q       <= vs_d;
            hr_q       <= hr_d;
            db_q       <= db_d;
            vs_prev_q  <= vs_prev_d;
            hr_prev_q  <= hr_prev_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            px_cnt_q   <= px_cnt_d;
            pixel_x_q  <= pixel_x_d;
            line_y_q   <= line_y_d;
            de_q       <= de_d;
            vsync_q    <= vsync_d;
            half_q     <= half_d;
            line_err_q <= line_err_d;
            bgr565_q   <= bgr565_d;
            bgr888_q   <= bgr888_d;
        end
    end

    assign cam.vsync         = vsync_q;
    assign cam.de            = de_q;
    assign cam.half_cmos_clk = half_q;
    assign cam.data_bgr565   = bgr565_q;
    assign cam.data_bgr888   = bgr888_q;
    assign cam.pixel_x       = pixel_x_q;
    assign cam.line_y        = line_y_q;
    assign cam.line_err      = line_err_q;
endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Scoreboard bench for cmos_pixel_capture: two instances (SKIP_FRAMES 0 and 2)
// share the sensor stimulus; each has its own frame-gate model and expected-pixel queue.
module tb_cmos_pixel_capture;
    localparam int CNT_W = 12;

    logic       clk = 1'b0;
    logic       rst, init, vs, href;
    logic [7:0] db;

    always #5 clk = ~clk;

    cmos_pixel_capture_if #(.CNT_W(CNT_W)) cam0 ();
    cmos_pixel_capture_if #(.CNT_W(CNT_W)) cam2 ();

    cmos_pixel_capture #(.SKIP_FRAMES(0), .CNT_W(CNT_W)) dut0 (
        .cmos_pclk(clk), .rst(rst), .cam_init_done(init), .cmos_vsync(vs),
        .cmos_href(href), .cmos_db(db), .cam(cam0.master));
    cmos_pixel_capture #(.SKIP_FRAMES(2), .CNT_W(CNT_W)) dut2 (
        .cmos_pclk(clk), .rst(rst), .cam_init_done(init), .cmos_vsync(vs),
        .cmos_href(href), .cmos_db(db), .cam(cam2.master));

    typedef struct {
        logic [15:0] pix;
        int unsigned x;
        int unsigned y;
        int unsigned cyc;
    } exp_t;

    exp_t        sb [2][$];
    int unsigned checks = 0, errors = 0, cyc = 0;
    bit          en [2], act [2];
    int unsigned cnt [2];
    int unsigned skipn [2] = '{0, 2};
    int unsigned le_seen [2] = '{0, 0};
    int unsigned le_exp = 0, y_model = 0;
    logic [7:0]  fixed_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to888(input logic [15:0] p);
        logic [7:0] b, g, r;
        b = (8'(p[15:11]) << 3) | (8'(p[15:11]) >> 2);
        g = (8'(p[10:5])  << 2) | (8'(p[10:5])  >> 4);
        r = (8'(p[4:0])   << 3) | (8'(p[4:0])   >> 2);
        return {b, g, r};
    endfunction

    task automatic mon(input int d, input logic de, input logic half, input logic le,
                       input logic [15:0] d565, input logic [23:0] d888,
                       input logic [CNT_W-1:0] px, input logic [CNT_W-1:0] ly);
        exp_t e;
        if (le) le_seen[d]++;
        if (de) begin
            check_eq($sformatf("half%0d", d), half, 1);
            if (sb[d].size() == 0) begin
                check_eq($sformatf("unexp_de%0d", d), sb[d].size(), 1);
            end else begin
                e = sb[d].pop_front();
                check_eq($sformatf("lat%0d", d), cyc, e.cyc);
                check_eq($sformatf("bgr565_%0d", d), d565, e.pix);
                check_eq($sformatf("bgr888_%0d", d), d888, to888(e.pix));
                check_eq($sformatf("pixel_x%0d", d), px, e.x);
                check_eq($sformatf("line_y%0d", d), ly, e.y);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, cam0.de, cam0.half_cmos_clk, cam0.line_err, cam0.data_bgr565,
                cam0.data_bgr888, cam0.pixel_x, cam0.line_y);
            mon(1, cam2.de, cam2.half_cmos_clk, cam2.line_err, cam2.data_bgr565,
                cam2.data_bgr888, cam2.pixel_x, cam2.line_y);
        end
    end

    task automatic reset_check();
        check_eq("rst_data0", {cam0.data_bgr565, cam0.data_bgr888}, 0);
        check_eq("rst_ctl0", {cam0.de, cam0.vsync, cam0.half_cmos_clk, cam0.line_err,
                              cam0.pixel_x, cam0.line_y}, 0);
        check_eq("rst_data2", {cam2.data_bgr565, cam2.data_bgr888}, 0);
        check_eq("rst_ctl2", {cam2.de, cam2.vsync, cam2.half_cmos_clk, cam2.line_err,
                              cam2.pixel_x, cam2.line_y}, 0);
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1 vs = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (en[d] && !act[d]) begin
                if (cnt[d] == skipn[d]) act[d] = 1'b1;
                else                    cnt[d]++;
            end
        end
        y_model = 0;
        @(posedge clk); @(negedge clk);
        check_eq("vs_lag0", cam0.vsync, 0);
        check_eq("vs_lag2", cam2.vsync, 0);
        @(posedge clk); @(negedge clk);
        check_eq("vs_on0", cam0.vsync, act[0]);
        check_eq("vs_on2", cam2.vsync, act[1]);
        @(posedge clk); #1 vs = 1'b0;
    endtask

    task automatic drive_line(input int nbytes, input int drop_at, input int abort_at);
        logic [7:0] hi, b;
        hi = '0;
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk);
            if (i == abort_at) begin
                #3 rst = 1'b1;
                #1 reset_check();
                for (int d = 0; d < 2; d++) begin
                    sb[d].delete();
                    act[d] = 1'b0;
                    cnt[d] = 0;
                end
                href = 1'b0;
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            #1;
            if (i == drop_at) begin
                init = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    if (act[d] && sb[d].size() > 0) void'(sb[d].pop_back());
                    en[d]  = 1'b0;
                    act[d] = 1'b0;
                    cnt[d] = 0;
                end
            end
            b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom_range(1, 255));
            href = 1'b1;
            db   = b;
            if (i % 2 == 0) hi = b;
            else begin
                for (int d = 0; d < 2; d++)
                    if (act[d]) sb[d].push_back('{pix: {hi, b}, x: i / 2, y: y_model, cyc: cyc + 2});
            end
        end
        if (nbytes % 2 != 0) le_exp++;
        @(posedge clk); #1 href = 1'b0;
        db = 8'($urandom);
        y_model++;
    endtask

    task automatic drain_check();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("drain0", sb[0].size(), 0);
        check_eq("drain2", sb[1].size(), 0);
    endtask

    task automatic drive_frame(input int first_bytes, input int bytes, input int lines);
        vs_pulse();
        repeat (2) @(posedge clk);
        for (int l = 0; l < lines; l++) drive_line((l == 0) ? first_bytes : bytes, -1, -1);
        drain_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; init = 1'b0; vs = 1'b0; href = 1'b0; db = '0;
        en = '{0, 0}; act = '{0, 0}; cnt = '{0, 0};
        repeat (2) @(posedge clk);
        #1 reset_check();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 init = 1'b1; en = '{1, 1};
        repeat (3) @(posedge clk);

        drive_frame(8, 8, 2);
        fixed_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
        drive_frame(8, 8, 2);
        drive_frame(8, 8, 2);
        drive_frame(5, 8, 2);
        drive_frame(1280, 1280, 3);
        drive_frame(8, 8, 2);

        // cam_init_done dropped mid-line, then reasserted
        vs_pulse();
        repeat (2) @(posedge clk);
        drive_line(8, 4, -1);
        drive_line(8, -1, -1);
        drain_check();
        #1 init = 1'b1; en = '{1, 1};
        repeat (3) @(posedge clk);
        drive_frame(8, 8, 2);
        drive_frame(8, 8, 2);
        drive_frame(8, 8, 2);

        // asynchronous reset after the high byte of a pixel
        vs_pulse();
        repeat (2) @(posedge clk);
        drive_line(8, -1, 5);
        repeat (3) @(posedge clk);
        drive_frame(8, 8, 2);
        drive_frame(8, 8, 2);
        drive_frame(8, 8, 2);

        check_eq("line_err0", le_seen[0], le_exp);
        check_eq("line_err2", le_seen[1], le_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
